// File: rtl/modbus_rtu_rx_frame.sv
// Modbus RTU frame receiver: T3.5 silence delimiting, CRC-16 and address check, buffered read port.
// Optional inter-character gap rejection is enabled by defining MODBUS_RTU_RX_T15_EN.
module modbus_rtu_rx_frame #(
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned T35_CYCLES = 1750,
  parameter int unsigned T15_CYCLES = 750
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] my_addr,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       frame_ready,
  output logic [8:0] frame_len,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       frame_bad,
  output logic [1:0] err_code
);

  localparam int unsigned SW = $clog2(T35_CYCLES + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [SW-1:0] T35 = SW'(T35_CYCLES);
  localparam logic [SW-1:0] T15 = SW'(T15_CYCLES);
  localparam logic [8:0] LEN_MAX = 9'(MAX_LEN);
  localparam logic [8:0] LEN_SAT = 9'(MAX_LEN + 1);

`ifdef MODBUS_RTU_RX_T15_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StInit, StIdle, StRecv, StCheck} state_e;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_e        state_q, state_d;
  logic [SW-1:0] sil_q, sil_d;
  logic [15:0]   crc_q, crc_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    addr_q, addr_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          gap_q, gap_d;
  logic          frame_ready_q, frame_ready_d;
  logic [8:0]    frame_len_q, frame_len_d;
  logic          frame_bad_q, frame_bad_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    rd_data_q;
  logic          wr_en;
  logic          expiry;

  logic [7:0] frame_mem [MAX_LEN];

  // A byte or error in the saturated cycle wins over ending the frame.
  assign expiry = (sil_q == T35) && !rx_valid && !rx_err;

  always_comb begin
    state_d       = state_q;
    sil_d         = sil_q;
    crc_d         = crc_q;
    count_d       = count_q;
    addr_d        = addr_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    busy_d        = busy_q;
    gap_d         = gap_q;
    frame_ready_d = frame_ready_q;
    frame_len_d   = frame_len_q;
    frame_bad_d   = 1'b0;
    err_code_d    = err_code_q;
    wr_en         = 1'b0;

    if (rx_valid || rx_err) begin
      sil_d = '0;
    end else if (sil_q != T35) begin
      sil_d = sil_q + 1'b1;
    end

    if (frame_ready_q && frame_ack) begin
      frame_ready_d = 1'b0;
    end

    unique case (state_q)
      StInit: begin
        if (expiry) state_d = StIdle;
      end

      StIdle: begin
        if (rx_valid) begin
          state_d = StRecv;
          count_d = 9'd1;
          crc_d   = crc16_byte(16'hFFFF, rx_data);
          addr_d  = rx_data;
          wr_en   = !frame_ready_q;
          busy_d  = frame_ready_q;
          err_d   = rx_err;
        end else if (rx_err) begin
          state_d = StRecv;
          err_d   = 1'b1;
        end
      end

      StRecv: begin
        if (rx_valid) begin
          if (count_q < LEN_MAX) begin
            wr_en = !frame_ready_q;
          end else begin
            ovf_d = 1'b1;
          end
          if (frame_ready_q) busy_d = 1'b1;
          if (count_q != LEN_SAT) count_d = count_q + 9'd1;
          crc_d = crc16_byte(crc_q, rx_data);
          if (GapEn && (sil_q > T15) && (sil_q < T35)) gap_d = 1'b1;
        end
        if (rx_err) err_d = 1'b1;
        if (expiry) state_d = StCheck;
      end

      StCheck: begin
        if (frame_ready_q || busy_q || err_q || ovf_q) begin
          frame_bad_d = 1'b1;
          err_code_d  = 2'd2;
        end else if (count_q < 9'd4) begin
          frame_bad_d = 1'b1;
          err_code_d  = 2'd1;
        end else if (gap_q) begin
          frame_bad_d = 1'b1;
          err_code_d  = 2'd3;
        end else if (crc_q != 16'h0000) begin
          frame_bad_d = 1'b1;
          err_code_d  = 2'd0;
        end else if ((addr_q == my_addr) || (addr_q == 8'h00)) begin
          frame_ready_d = 1'b1;
          frame_len_d   = count_q - 9'd2;
        end
        crc_d   = 16'hFFFF;
        count_d = '0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        busy_d  = 1'b0;
        gap_d   = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StInit;
      sil_q         <= '0;
      crc_q         <= 16'hFFFF;
      count_q       <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      gap_q         <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_len_q   <= '0;
      frame_bad_q   <= 1'b0;
      err_code_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      sil_q         <= sil_d;
      crc_q         <= crc_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      gap_q         <= gap_d;
      frame_ready_q <= frame_ready_d;
      frame_len_q   <= frame_len_d;
      frame_bad_q   <= frame_bad_d;
      err_code_q    <= err_code_d;
      rd_data_q     <= (32'(rd_addr) < MAX_LEN) ? frame_mem[rd_addr[AW-1:0]] : 8'h00;
    end
  end

  // Buffer storage carries no reset; contents are only meaningful while frame_ready is high.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      frame_mem[count_q[AW-1:0]] <= rx_data;
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_len   = frame_len_q;
  assign frame_bad   = frame_bad_q;
  assign err_code    = err_code_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_modbus_rtu_rx_frame.sv
// Scoreboard bench for modbus_rtu_rx_frame: directed frames, queued expected outcomes,
// independent monitor compares frame_ready / frame_bad events.
module tb_modbus_rtu_rx_frame;

  localparam int unsigned T35 = 200;
  localparam int unsigned T15 = 80;
  localparam int unsigned GAP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] my_addr = 8'h01;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       frame_ready;
  logic [8:0] frame_len;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       frame_ack = 1'b0;
  logic       frame_bad;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  modbus_rtu_rx_frame #(
    .MAX_LEN   (256),
    .T35_CYCLES(T35),
    .T15_CYCLES(T15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .my_addr    (my_addr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .frame_ready(frame_ready),
    .frame_len  (frame_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_ack  (frame_ack),
    .frame_bad  (frame_bad),
    .err_code   (err_code)
  );

  typedef struct {
    bit         good;
    logic [1:0] code;
    logic [8:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] frame_a [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
  logic [7:0] frame_b [8] = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_good(input logic [8:0] len);
    exp_t e;
    e.good = 1'b1; e.code = 2'd0; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_bad(input logic [1:0] code);
    exp_t e;
    e.good = 1'b0; e.code = code; e.len = 9'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic ready_prev = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (frame_bad) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_bad", {30'd0, err_code}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_bad", {31'd0, e.good}, 32'd0);
        check("err_code", {30'd0, err_code}, {30'd0, e.code});
      end
    end
    if (frame_ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_ready", {23'd0, frame_len}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_ready", {31'd0, e.good}, 32'd1);
        check("frame_len", {23'd0, frame_len}, {23'd0, e.len});
      end
    end
    ready_prev = frame_ready;
  end

  task automatic send_byte(input logic [7:0] b, input bit err, input int unsigned gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // err_idx / long_gap_idx of -1 disable the respective disturbance.
  task automatic send_frame(input logic [7:0] f [8], input logic [7:0] last, input int err_idx,
                            input int long_gap_idx);
    for (int i = 0; i < 8; i++) begin
      if (i == long_gap_idx) repeat (100) @(negedge clk);
      send_byte((i == 7) ? last : f[i], (i == err_idx), GAP);
    end
  endtask

  task automatic settle();
    repeat (T35 + 30) @(negedge clk);
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < int'(T35) + 100; i++) begin
      if (frame_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_ready_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic read_check(input logic [7:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = idx;
    @(negedge clk);
    check($sformatf("rd_data[%0d]", idx), {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check("ready_after_ack", {31'd0, frame_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_ready"}, {31'd0, frame_ready}, 32'd0);
    check({tag, "_frame_len"}, {23'd0, frame_len}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    check({tag, "_frame_bad"}, {31'd0, frame_bad}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    settle();

    // Valid frame, read back and release.
    my_addr = 8'h01;
    push_good(9'd6);
    send_frame(frame_a, 8'h0A, -1, -1);
    wait_ready();
    for (int i = 0; i < 6; i++) read_check(8'(i), frame_a[i]);
    ack();

    // Bad CRC.
    push_bad(2'd0);
    send_frame(frame_a, 8'h0B, -1, -1);
    settle();
    check("badcrc_no_ready", {31'd0, frame_ready}, 32'd0);

    // Address mismatch: silent drop, then accepted with matching address.
    my_addr = 8'h11;
    send_frame(frame_a, 8'h0A, -1, -1);
    settle();
    check("mismatch_no_ready", {31'd0, frame_ready}, 32'd0);
    my_addr = 8'h01;
    push_good(9'd6);
    send_frame(frame_a, 8'h0A, -1, -1);
    wait_ready();
    ack();

    // Short frame.
    push_bad(2'd1);
    for (int i = 0; i < 3; i++) send_byte(frame_a[i], 1'b0, GAP);
    settle();

    // rx_err on byte 2.
    push_bad(2'd2);
    send_frame(frame_a, 8'h0A, 1, -1);
    settle();

    // Overflow.
    push_bad(2'd2);
    for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b0, 2);
    settle();

    // Busy: hold first frame, second one rejected, buffer untouched.
    push_good(9'd6);
    send_frame(frame_a, 8'h0A, -1, -1);
    wait_ready();
    push_bad(2'd2);
    send_frame(frame_b, 8'h0B, -1, -1);
    settle();
    check("busy_ready_held", {31'd0, frame_ready}, 32'd1);
    for (int i = 0; i < 6; i++) read_check(8'(i), frame_a[i]);
    ack();

`ifdef MODBUS_RTU_RX_T15_EN
    push_bad(2'd3);
    send_frame(frame_a, 8'h0A, -1, 4);
    settle();
`endif

    // Reset mid-frame, then INIT discards traffic until T3.5 silence.
    for (int i = 0; i < 4; i++) send_byte(frame_a[i], 1'b0, GAP);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    send_frame(frame_a, 8'h0A, -1, -1);
    settle();
    check("init_discard_no_ready", {31'd0, frame_ready}, 32'd0);
    push_good(9'd6);
    send_frame(frame_a, 8'h0A, -1, -1);
    wait_ready();
    read_check(8'd0, 8'h01);
    read_check(8'd1, 8'h03);
    ack();

    settle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
